// File: rtl/p_lpf_iir.sv
// First-order IIR low-pass on single-precision active power:
//   y[n] = y[n-1] + K * (P[n] - y[n-1])
// One shared adder/subtractor and one multiplier, both pipelined,
// sequenced by a small FSM. The first sample after reset presets y.
module p_lpf_iir #(
  parameter int ADD_LAT = 7,
  parameter int MUL_LAT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sta,
  input  logic [31:0] P_in,
  input  logic [31:0] K,
  output logic [31:0] P_filt,
  output logic        done_sig,
  output logic        busy,
  output logic        overrun
);

  // Pipeline stages inside each core; the capture register in the FSM
  // provides the final stage, so operands-to-captured-result is *_LAT clocks.
  localparam int unsigned ADD_D = (ADD_LAT > 1) ? ADD_LAT - 1 : 0;
  localparam int unsigned MUL_D = (MUL_LAT > 1) ? MUL_LAT - 1 : 0;
  localparam logic [7:0] ADD_LAST = 8'(ADD_LAT - 1);
  localparam logic [7:0] MUL_LAST = 8'(MUL_LAT - 1);

  typedef enum logic [2:0] {IDLE, PRESET, SUB, MUL, ACC, DONE} state_t;

  state_t      state;
  logic        first_flag;
  logic [7:0]  cnt;
  logic [31:0] p_hold, k_hold, diff_q, prod_q, sum_q;
  logic [31:0] add_a, add_b, add_res, add_out;
  logic [31:0] mul_res, mul_out;

  // IEEE-754 single add, round-to-nearest-even, denormals flushed to zero.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic               sx, sy;
    logic [7:0]         ex, ey, d;
    logic [22:0]        fx, fy;
    logic [27:0]        mx, my, acc, mask;
    logic               stk, rup;
    logic signed [9:0]  e;
    logic [24:0]        rnd;
    if (a[30:23] == 8'hff) return a;
    if (b[30:23] == 8'hff) return b;
    if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return {a[31] & b[31], 31'b0};
    if (a[30:23] == 8'h00) return b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:0] >= b[30:0]) begin
      sx = a[31]; ex = a[30:23]; fx = a[22:0];
      sy = b[31]; ey = b[30:23]; fy = b[22:0];
    end else begin
      sx = b[31]; ex = b[30:23]; fx = b[22:0];
      sy = a[31]; ey = a[30:23]; fy = a[22:0];
    end
    mx = {2'b01, fx, 3'b000};
    my = {2'b01, fy, 3'b000};
    d  = ex - ey;
    if (d >= 8'd27) begin
      my = 28'd1;
    end else begin
      mask = (28'd1 << d) - 28'd1;
      stk  = |(my & mask);
      my   = (my >> d) | {27'b0, stk};
    end
    acc = (sx == sy) ? (mx + my) : (mx - my);
    if (acc == '0) return '0;
    e = $signed({2'b00, ex});
    if (acc[27]) begin
      acc = (acc >> 1) | {27'b0, acc[0]};
      e   = e + 10'sd1;
    end else begin
      for (int unsigned i = 0; i < 26; i++) begin
        if (!acc[26]) begin
          acc = acc << 1;
          e   = e - 10'sd1;
        end
      end
    end
    rup = acc[2] & (acc[1] | acc[0] | acc[3]);
    rnd = {1'b0, acc[26:3]} + {24'b0, rup};
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e   = e + 10'sd1;
    end
    if (e >= 10'sd255) return {sx, 8'hff, 23'b0};
    if (e <= 10'sd0)   return {sx, 31'b0};
    return {sx, e[7:0], rnd[22:0]};
  endfunction

  // IEEE-754 single multiply, round-to-nearest-even, denormals flushed to zero.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic               s, g, stk, rup;
    logic [47:0]        p;
    logic [23:0]        m;
    logic signed [9:0]  e;
    logic [24:0]        rnd;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hff || b[30:23] == 8'hff) return {s, 8'hff, 23'b0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'b0};
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m = p[47:24]; g = p[23]; stk = |p[22:0];
      e = e + 10'sd1;
    end else begin
      m = p[46:23]; g = p[22]; stk = |p[21:0];
    end
    rup = g & (stk | m[0]);
    rnd = {1'b0, m} + {24'b0, rup};
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e   = e + 10'sd1;
    end
    if (e >= 10'sd255) return {s, 8'hff, 23'b0};
    if (e <= 10'sd0)   return {s, 31'b0};
    return {s, e[7:0], rnd[22:0]};
  endfunction

  // Operand selection: subtract P_hold - y everywhere except ACC (y + prod).
  always_comb begin
    add_a = p_hold;
    add_b = {~P_filt[31], P_filt[30:0]};
    if (state == ACC) begin
      add_a = P_filt;
      add_b = prod_q;
    end
    add_res = fadd(add_a, add_b);
    mul_res = fmul(k_hold, diff_q);
  end

  generate
    if (ADD_D == 0) begin : g_add_comb
      assign add_out = add_res;
    end else begin : g_add_pipe
      logic [31:0] pipe [ADD_D];
      // Adder pipeline, flushed by reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < ADD_D; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= add_res;
          for (int unsigned i = 1; i < ADD_D; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign add_out = pipe[ADD_D-1];
    end

    if (MUL_D == 0) begin : g_mul_comb
      assign mul_out = mul_res;
    end else begin : g_mul_pipe
      logic [31:0] pipe [MUL_D];
      // Multiplier pipeline, flushed by reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < MUL_D; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= mul_res;
          for (int unsigned i = 1; i < MUL_D; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign mul_out = pipe[MUL_D-1];
    end
  endgenerate

  // Sequencer with registered outputs.
  // Outputs are registered, so the preset result is loaded on the accepting
  // edge (visible while in PRESET) and the DONE-state update is visible the
  // following cycle; busy is held through that visible done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      P_filt     <= '0;
      done_sig   <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      first_flag <= 1'b1;
      cnt        <= '0;
      p_hold     <= '0;
      k_hold     <= '0;
      diff_q     <= '0;
      prod_q     <= '0;
      sum_q      <= '0;
    end else begin
      done_sig <= 1'b0;
      if (sta && busy) overrun <= 1'b1;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (sta && !busy) begin
            p_hold <= P_in;
            if (first_flag) begin
              P_filt   <= P_in;
              done_sig <= 1'b1;
              state    <= PRESET;
            end else begin
              k_hold <= K;
              busy   <= 1'b1;
              cnt    <= '0;
              state  <= SUB;
            end
          end
        end
        PRESET: begin
          first_flag <= 1'b0;
          state      <= IDLE;
        end
        SUB: begin
          if (cnt == ADD_LAST) begin
            diff_q <= add_out;
            cnt    <= '0;
            state  <= MUL;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        MUL: begin
          if (cnt == MUL_LAST) begin
            prod_q <= mul_out;
            cnt    <= '0;
            state  <= ACC;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ACC: begin
          if (cnt == ADD_LAST) begin
            sum_q <= add_out;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          P_filt   <= sum_q;
          done_sig <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p_lpf_iir.sv
// Bench for p_lpf_iir: cycle-level behavioural model (real arithmetic
// rounded to single) compared against the DUT every cycle, plus directed
// literal checks and randomized samples.
module tb_p_lpf_iir;

  logic        clk = 1'b0;
  logic        rst, sta;
  logic [31:0] P_in, K;
  logic [31:0] P_filt;
  logic        done_sig, busy, overrun;

  int n_cmp = 0;
  int n_bad = 0;

  p_lpf_iir #(.ADD_LAT(7), .MUL_LAT(5)) dut (
    .clk(clk), .rst(rst), .sta(sta), .P_in(P_in), .K(K),
    .P_filt(P_filt), .done_sig(done_sig), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  localparam int LATENCY = 2 * 7 + 5 + 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // single -> real (exact), flushing denormals
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h00) d = {f[31], 63'b0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  // real -> single, round to nearest even
  function automatic logic [31:0] r2f(input real r);
    logic [63:0]       d;
    logic signed [12:0] e;
    logic [24:0]       m;
    logic              g, st;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'b0};
    e  = $signed({2'b00, d[62:52]}) - 13'sd896;
    m  = {2'b01, d[51:29]};
    g  = d[28];
    st = |d[27:0];
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin m = m >> 1; e = e + 13'sd1; end
    if (e >= 13'sd255) return {d[63], 8'hff, 23'b0};
    if (e <= 13'sd0) return {d[63], 31'b0};
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] filt(input logic [31:0] y, input logic [31:0] p, input logic [31:0] k);
    logic [31:0] diff, prod;
    diff = r2f(f2r(p) - f2r(y));
    prod = r2f(f2r(k) * f2r(diff));
    return r2f(f2r(y) + f2r(prod));
  endfunction

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  logic [31:0] m_y = '0, pend_y = '0;
  int          pend_at = -1, busy_lo = 0, busy_hi = -1;
  logic        m_first = 1'b1, m_ovr = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_y = '0; pend_at = -1; busy_lo = 0; busy_hi = -1;
      m_first = 1'b1; m_ovr = 1'b0;
    end else if (sta) begin
      if (cyc - 1 >= busy_lo && cyc - 1 <= busy_hi) begin
        m_ovr = 1'b1;
      end else if (m_first) begin
        pend_at = cyc; pend_y = P_in; m_first = 1'b0;
      end else begin
        busy_lo = cyc; busy_hi = cyc + LATENCY - 1;
        pend_at = cyc + LATENCY - 1;
        pend_y  = filt(m_y, P_in, K);
      end
    end
    if (cyc == pend_at) m_y = pend_y;
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("done_sig", {31'b0, done_sig}, {31'b0, cyc == pend_at});
      check("busy", {31'b0, busy}, {31'b0, cyc >= busy_lo && cyc <= busy_hi});
      check("overrun", {31'b0, overrun}, {31'b0, m_ovr});
      check("P_filt", P_filt, m_y);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [31:0] p, input logic [31:0] k);
    sta = 1'b1; P_in = p; K = k;
    tick(1);
    sta = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sta = 1'b0; P_in = '0; K = '0;
    tick(3);
    rst = 1'b0;
    check("rst_pfilt", P_filt, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done_sig}, 32'h0);
    tick(2);

    // preset path
    pulse(32'h42C80000, 32'h3F000000);
    check("preset_done", {31'b0, done_sig}, 32'h1);
    check("preset_val", P_filt, 32'h42C80000);
    check("preset_busy", {31'b0, busy}, 32'h0);
    tick(2);

    // 100 -> 200 at K=0.5
    pulse(32'h43480000, 32'h3F000000);
    check("upd_busy", {31'b0, busy}, 32'h1);
    tick(LATENCY - 2);
    check("upd_early", {31'b0, done_sig}, 32'h0);
    tick(1);
    check("upd_done", {31'b0, done_sig}, 32'h1);
    check("upd_150", P_filt, 32'h43160000);
    check("model_150", m_y, 32'h43160000);
    tick(1);

    // K=1 tracks input
    pulse(32'hC2480000, 32'h3F800000);
    tick(LATENCY - 1);
    check("k1_val", P_filt, 32'hC2480000);
    tick(1);

    // K=0 holds
    pulse(32'h447A0000, 32'h00000000);
    tick(LATENCY - 1);
    check("k0_val", P_filt, 32'hC2480000);
    tick(1);

    // stray sta mid-update and in the done cycle
    pulse(32'h42C80000, 32'h3F000000);
    tick(4);
    pulse(32'h447A0000, 32'h3F800000);
    tick(LATENCY - 6);
    check("ovr_done", {31'b0, done_sig}, 32'h1);
    check("ovr_val", P_filt, 32'h41C80000);
    check("model_25", m_y, 32'h41C80000);
    pulse(32'h447A0000, 32'h3F800000);
    check("ovr_flag", {31'b0, overrun}, 32'h1);
    tick(30);
    check("ovr_sticky", {31'b0, overrun}, 32'h1);

    // reset mid-update
    pulse(32'h43480000, 32'h3F000000);
    tick(9);
    do_reset();
    check("abort_pfilt", P_filt, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_ovr", {31'b0, overrun}, 32'h0);
    tick(LATENCY);
    pulse(32'h41200000, 32'h3F000000);
    check("re_preset_done", {31'b0, done_sig}, 32'h1);
    check("re_preset_val", P_filt, 32'h41200000);
    tick(1);

    // back-to-back at minimum spacing
    for (int i = 0; i < 20; i++) begin
      pulse((i % 2 == 0) ? 32'h42C80000 : 32'h43480000, 32'h3F000000);
      tick(LATENCY);
    end
    check("b2b_ovr", {31'b0, overrun}, 32'h0);

    // randomized samples with occasional stray strobes
    do_reset();
    tick(2);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] p, k;
      int off;
      p = {1'($urandom), 8'($urandom_range(127, 140)), 23'($urandom)};
      k = ($urandom_range(0, 7) == 0) ? 32'h3F800000
          : {1'b0, 8'($urandom_range(117, 126)), 23'($urandom)};
      pulse(p, k);
      if (i == 0) begin
        tick(1);
      end else if ($urandom_range(0, 5) == 0) begin
        off = $urandom_range(1, LATENCY);
        tick(off - 1);
        pulse({1'($urandom), 8'($urandom_range(127, 140)), 23'($urandom)}, 32'h3F800000);
        tick(LATENCY - off);
      end else begin
        tick(LATENCY);
      end
      tick($urandom_range(0, 4));
    end
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/p_lpf_iir.md
Name: p_lpf_iir

Overview:
- First-order IIR low-pass filter on the single-precision three-phase active-power result P.
- Sits directly downstream of the filterless power calculator; consumes its P word and done_sig pulse.
- Computes y[n] = y[n-1] + K*(P[n] - y[n-1]) using the team's floating-point adder/multiplier IP cores under a sequencing FSM.
- Emits the filtered power with a one-cycle done pulse for the next stage (control/measurement).

Parameters:
- ADD_LAT, 7, pipeline latency in clocks of the floating-point adder/subtractor core (Adder_nodsp).
- MUL_LAT, 5, pipeline latency in clocks of the floating-point multiplier core (Multiplier_nodsp_dsp).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- sta  input  1  one-cycle strobe: P_in valid (driven from the upstream done_sig)
- P_in  input  `SINGLE  unfiltered active power, IEEE-754 single
- K  input  `SINGLE  filter coefficient, single, range 0.0..1.0, sampled with sta
- P_filt  output  `SINGLE  filtered power y, held between updates
- done_sig  output  1  one-cycle pulse: P_filt updated this cycle
- busy  output  1  high while a filter update is in flight
- overrun  output  1  sticky: sta arrived while busy

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): P_filt=0x00000000, done_sig=0, busy=0, overrun=0, FSM to IDLE, first_flag=1, wait counter=0. Arithmetic core pipelines are cleared by rst. Reset mid-operation aborts the update; no done_sig is produced for the aborted sample.
- FSM states: IDLE, PRESET, SUB, MUL, ACC, DONE.
- IDLE, sta=1, first_flag=1: latch P_in, go to PRESET.
- PRESET: P_filt <= latched P, first_flag <= 0, done_sig=1 for this cycle, return to IDLE. Latency is 1 cycle after the sta cycle; K is ignored.
- IDLE, sta=1, first_flag=0: latch P_in and K into holding registers; busy=1; go to SUB.
- SUB: adder in subtract mode computes diff = P_hold - P_filt. Stay ADD_LAT cycles, counted by a wait counter, then capture diff.
- MUL: prod = K_hold * diff. Stay MUL_LAT cycles, then capture prod.
- ACC: adder in add mode computes sum = P_filt + prod. Stay ADD_LAT cycles.
- DONE: P_filt <= sum, done_sig=1 for exactly one cycle, busy=0, return to IDLE.
- Filter latency: done_sig asserts exactly 2*ADD_LAT+MUL_LAT+2 cycles after the sta cycle (21 with default parameters).
- busy: high from the cycle after sta through the DONE cycle inclusive.
- Core inputs are held stable for the whole wait period of each state. P_filt is only written in PRESET or DONE.
- sta while busy=1: the sample is ignored, holding registers are unchanged, overrun <= 1. overrun clears only on rst.
- sta in the DONE cycle counts as busy (ignored, overrun set).
- sta in the cycle after DONE (IDLE) is accepted normally.
- done_sig never asserts in two consecutive cycles.
- No special handling of NaN/Inf/denormals: results are whatever the cores produce.
- K=0.0 holds y; K=1.0 makes y track P_in.

Test Plan:
- Reset, then sta with P_in=0x42C80000 (100.0) -> done_sig 1 cycle later; P_filt=0x42C80000; busy stays 0.
- Continue: sta with P_in=0x43480000 (200.0) and K=0x3F000000 (0.5) -> busy the next cycle; done_sig exactly 21 cycles after sta; P_filt=0x43160000 (150.0).
- Continue: K=0x3F800000 (1.0), P_in=0xC2480000 (-50.0) -> P_filt=0xC2480000. Then K=0x00000000, P_in=0x447A0000 -> P_filt unchanged at 0xC2480000.
- During an update, pulse sta with P_in=0x447A0000 at cycle 5 and in the DONE cycle -> both ignored; the result equals the original sample's result; overrun=1 and it stays 1 until rst.
- Assert rst for 1 cycle at cycle 10 of an update -> P_filt=0, busy=0, no done_sig. The next sta with P_in=0x41200000 (10.0) takes the PRESET path (done 1 cycle later, P_filt=0x41200000).
- Back-to-back samples: drive sta every 22 cycles with alternating 100.0/200.0 at K=0.5 -> every sample accepted, overrun stays 0, the P_filt sequence matches a golden float model bit-exactly.
